multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
Consumes the fetch stage's instruction/valid pair and sequences one instruction at a time through the multicycle datapath. It decodes fields, drives the datapath controls for execute, memory and write-back, and returns PCSrc/JA/BTA plus a PC-update strobe to fetch. It is a single FSM sitting directly downstream of instruction fetch.

Parameters:
ADDR_W, 32, PC/address width
REG_IDX_W, 5, register index width
LINK_REG, 31, destination register for the JAL return address

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low; 0 = reset
instruction  in  32  from fetch
valid  in  1  instruction is valid this cycle
pc  in  ADDR_W  PC of the current instruction
alu_zero  in  1  ALU zero flag, sampled in EXEC
PCSrc  out  2  00 = PC+1, 01 = jump, 10 = branch
JA  out  ADDR_W  jump offset
BTA  out  ADDR_W  branch target
pc_en  out  1  one-cycle PC-update strobe
rs1, rs2, rd  out  REG_IDX_W  register indices
imm32  out  32  extended immediate
shamt  out  5  shift amount
alu_op  out  4  ALU operation code
alu_src  out  1  1 = immediate operand
mem_read, mem_write  out  1  data memory strobes
reg_write  out  1  register file write enable
wb_sel  out  2  00 = ALU, 01 = memory, 10 = PC+1
illegal  out  1  one-cycle pulse on an undefined opcode
busy  out  1  FSM not in FETCH

Behaviour:
- Reset (reset == 0 at posedge): state = FETCH; every output is 0, including PCSrc = 00 and JA/BTA/imm32 = 0. Reset is honoured in any state, so an in-flight instruction is abandoned and nothing is written.
- Instruction fields:
  - func = [31:27], rs1 = [26:22], rd = [21:17], rs2 = [16:12]
  - imm16 = [16:1], off26 = [26:1], sa = [11:7]
  - type = [2:1]: 00 = R, 01 = J, 10 = I, 11 = S
  - stop = [0]
- Opcodes by type:
  - R: AND 0, ADD 1, SUB 2, CAM 3
  - I: ANDI 0 (zero-extended imm), ADDI 1, LW 2, SW 3, BEQ 4 (sign-extended imm)
  - J: J 0, JAL 1
  - S: SLL 0, SLR 1 (shift by sa); SLLV 2, SLRV 3 (shift by rs2)
- States: FETCH, DECODE, EXEC, MEM, WB.
- FETCH: waits while valid == 0. When valid == 1, the instruction is captured into an internal IR and the FSM goes to DECODE. Fetch input is ignored in all other states.
- DECODE: decoded outputs are registered from the IR and held stable until the next FETCH capture.
  - J/JAL: JA = sign-extended off26.
  - BEQ: BTA = pc + sign-extended imm16, 32-bit wrap-around.
- Latency from capture to pc_en (cycles):
  - R, S, ALU-I: DECODE, EXEC, WB = 3
  - LW: DECODE, EXEC, MEM, WB = 4
  - SW: DECODE, EXEC, MEM = 3
  - BEQ: DECODE, EXEC = 2
  - J: DECODE = 1
  - JAL: DECODE, WB = 2
- Strobe rules:
  - pc_en pulses for exactly 1 cycle in the final state of each instruction, and the FSM then returns to FETCH.
  - PCSrc is valid during the pc_en cycle: 01 for J/JAL; 10 for BEQ with alu_zero == 1; 00 otherwise.
- Per-state controls:
  - mem_read (LW) and mem_write (SW) are asserted only in MEM.
  - reg_write is asserted only in WB.
  - JAL: rd = LINK_REG and wb_sel = 10.
- alu_op encoding: 0 AND, 1 ADD, 2 SUB, 3 CAM, 4 SLL, 5 SLR. EXEC uses ADD for LW/SW and SUB for BEQ.
- Undefined func for a given type: illegal pulses in DECODE; pc_en pulses in the same cycle with PCSrc = 00; no register or memory write occurs; the FSM returns to FETCH.
- busy = 1 in every state except FETCH.

Optional Feature:
STOP_BIT_HALT_EN
- Defined: an instruction with stop = 1 completes normally, then the FSM enters HALT instead of FETCH.
  - HALT sets busy = 1, never asserts pc_en, and ignores valid.
  - Only reset exits HALT.
- Undefined: the stop bit is ignored and there is no HALT state.

Test Plan:
- ADD: reset low for 2 cycles, then valid with 0x0CC07000 -> alu_op = 1, reg_write high in the 3rd cycle after capture, pc_en with PCSrc = 00 in that cycle.
- LW then SW: 0x11C00034 then 0x19C00034 -> LW: mem_read in cycle 3, reg_write with wb_sel = 01 in cycle 4. SW: mem_write in cycle 3 with no reg_write. Both: imm32 = 0x1A.
- BEQ: 0x21CE0084 with pc = 8 -> BTA = 0x4A. alu_zero = 1 gives PCSrc = 10; alu_zero = 0 gives PCSrc = 00. pc_en in cycle 2 in both cases.
- Jumps: J 0x00000042 -> JA = 0x21, PCSrc = 01, pc_en in cycle 1. JAL 0x08001F42 -> JA = 0xFA1, rd = 31, wb_sel = 10, reg_write in cycle 2.
- Illegal opcode: R-type func 7 -> illegal and pc_en in the DECODE cycle, no writes. Separately, reset asserted during the MEM cycle of an LW -> mem_read and all outputs 0 next cycle, state = FETCH.
- Idle and stop bit: valid held low -> FSM stays in FETCH with busy = 0. With STOP_BIT_HALT_EN defined, ADD with bit 0 = 1 -> normal completion, then busy stays 1 and no further pc_en.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Fetch/datapath-facing bus of the multicycle control unit.
// master = fetch/datapath side, slave = control unit.
interface multicycle_control_unit_if #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned REG_IDX_W = 5
);
  logic [31:0]          instruction;
  logic                 valid;
  logic [ADDR_W-1:0]    pc;
  logic                 alu_zero;
  logic [1:0]           PCSrc;
  logic [ADDR_W-1:0]    JA;
  logic [ADDR_W-1:0]    BTA;
  logic                 pc_en;
  logic [REG_IDX_W-1:0] rs1;
  logic [REG_IDX_W-1:0] rs2;
  logic [REG_IDX_W-1:0] rd;
  logic [31:0]          imm32;
  logic [4:0]           shamt;
  logic [3:0]           alu_op;
  logic                 alu_src;
  logic                 mem_read;
  logic                 mem_write;
  logic                 reg_write;
  logic [1:0]           wb_sel;
  logic                 illegal;
  logic                 busy;

  modport master (
    output instruction, valid, pc, alu_zero,
    input  PCSrc, JA, BTA, pc_en, rs1, rs2, rd, imm32, shamt, alu_op, alu_src,
    input  mem_read, mem_write, reg_write, wb_sel, illegal, busy
  );

  modport slave (
    input  instruction, valid, pc, alu_zero,
    output PCSrc, JA, BTA, pc_en, rs1, rs2, rd, imm32, shamt, alu_op, alu_src,
    output mem_read, mem_write, reg_write, wb_sel, illegal, busy
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Single-FSM control unit sequencing one instruction at a time through a multicycle datapath.
// Optional STOP_BIT_HALT_EN: instructions with the stop bit set park the FSM in HALT until reset.
module multicycle_control_unit #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned REG_IDX_W = 5,
  parameter int unsigned LINK_REG  = 31
) (
  input logic                      clk,
  input logic                      reset,
  multicycle_control_unit_if.slave bus
);

`ifdef STOP_BIT_HALT_EN
  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;
`else
  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;
`endif

  typedef enum logic [2:0] {KindAlu, KindLw, KindSw, KindBeq, KindJ, KindJal, KindIll} kind_e;

  state_e state_q, state_d;
  kind_e  kind_q, kind_d;

  logic [REG_IDX_W-1:0] rs1_q, rs2_q, rd_q, rd_d;
  logic [31:0]          imm_q, imm_d;
  logic [4:0]           shamt_q, shamt_d;
  logic [3:0]           alu_op_q, alu_op_d;
  logic                 alu_src_q, alu_src_d;
  logic [1:0]           wb_sel_q, wb_sel_d;
  logic [ADDR_W-1:0]    ja_q, ja_d, bta_q, bta_d;

  logic [4:0]  func;
  logic [1:0]  itype;
  logic [15:0] imm16;
  logic [25:0] off26;
  logic [31:0] imm_sext;
  logic        capture;

  assign func     = bus.instruction[31:27];
  assign itype    = bus.instruction[2:1];
  assign imm16    = bus.instruction[16:1];
  assign off26    = bus.instruction[26:1];
  assign imm_sext = {{16{imm16[15]}}, imm16};
  assign capture  = (state_q == StFetch) && bus.valid;

  // Decode straight from the fetch bus so the fields are already valid during DECODE.
  always_comb begin
    kind_d    = KindIll;
    rd_d      = REG_IDX_W'(bus.instruction[21:17]);
    imm_d     = '0;
    shamt_d   = '0;
    alu_op_d  = 4'd0;
    alu_src_d = 1'b0;
    wb_sel_d  = 2'b00;
    ja_d      = '0;
    bta_d     = '0;
    case (itype)
      2'b00: begin
        if (func < 5'd4) begin
          kind_d   = KindAlu;
          alu_op_d = 4'(func);
        end
      end
      2'b01: begin
        if (func == 5'd0 || func == 5'd1) begin
          kind_d = (func == 5'd0) ? KindJ : KindJal;
          ja_d   = {{(ADDR_W-26){off26[25]}}, off26};
          if (func == 5'd1) begin
            rd_d     = REG_IDX_W'(LINK_REG);
            wb_sel_d = 2'b10;
          end
        end
      end
      2'b10: begin
        case (func)
          5'd0: begin
            kind_d    = KindAlu;
            alu_op_d  = 4'd0;
            alu_src_d = 1'b1;
            imm_d     = {16'h0000, imm16};
          end
          5'd1: begin
            kind_d    = KindAlu;
            alu_op_d  = 4'd1;
            alu_src_d = 1'b1;
            imm_d     = imm_sext;
          end
          5'd2, 5'd3: begin
            kind_d    = (func == 5'd2) ? KindLw : KindSw;
            alu_op_d  = 4'd1;
            alu_src_d = 1'b1;
            imm_d     = imm_sext;
            wb_sel_d  = (func == 5'd2) ? 2'b01 : 2'b00;
          end
          5'd4: begin
            kind_d   = KindBeq;
            alu_op_d = 4'd2;
            imm_d    = imm_sext;
            bta_d    = bus.pc + {{(ADDR_W-16){imm16[15]}}, imm16};
          end
          default: ;
        endcase
      end
      default: begin
        if (func < 5'd4) begin
          kind_d   = KindAlu;
          alu_op_d = func[0] ? 4'd5 : 4'd4;
          shamt_d  = func[1] ? 5'd0 : bus.instruction[11:7];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      kind_q    <= KindAlu;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      shamt_q   <= '0;
      alu_op_q  <= '0;
      alu_src_q <= 1'b0;
      wb_sel_q  <= 2'b00;
      ja_q      <= '0;
      bta_q     <= '0;
    end else if (capture) begin
      kind_q    <= kind_d;
      rs1_q     <= REG_IDX_W'(bus.instruction[26:22]);
      rs2_q     <= REG_IDX_W'(bus.instruction[16:12]);
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      shamt_q   <= shamt_d;
      alu_op_q  <= alu_op_d;
      alu_src_q <= alu_src_d;
      wb_sel_q  <= wb_sel_d;
      ja_q      <= ja_d;
      bta_q     <= bta_d;
    end
  end

`ifdef STOP_BIT_HALT_EN
  logic stop_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      stop_q <= 1'b0;
    end else if (capture) begin
      stop_q <= bus.instruction[0];
    end
  end
`else
  logic unused_stop;
  assign unused_stop = bus.instruction[0];
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  logic       done, pc_en, mem_read, mem_write, reg_write, illegal;
  logic [1:0] pc_src;

  always_comb begin
    state_d   = state_q;
    done      = 1'b0;
    pc_src    = 2'b00;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      StFetch: if (bus.valid) state_d = StDecode;
      StDecode: begin
        case (kind_q)
          KindJ: begin
            done   = 1'b1;
            pc_src = 2'b01;
          end
          KindIll: begin
            done    = 1'b1;
            illegal = 1'b1;
          end
          KindJal: state_d = StWb;
          default: state_d = StExec;
        endcase
      end
      StExec: begin
        case (kind_q)
          KindBeq: begin
            done   = 1'b1;
            pc_src = bus.alu_zero ? 2'b10 : 2'b00;
          end
          KindLw, KindSw: state_d = StMem;
          default:        state_d = StWb;
        endcase
      end
      StMem: begin
        if (kind_q == KindLw) begin
          mem_read = 1'b1;
          state_d  = StWb;
        end else begin
          mem_write = 1'b1;
          done      = 1'b1;
        end
      end
      StWb: begin
        reg_write = 1'b1;
        done      = 1'b1;
        pc_src    = (kind_q == KindJal) ? 2'b01 : 2'b00;
      end
`ifdef STOP_BIT_HALT_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StFetch;
    endcase
    pc_en = done;
    if (done) begin
`ifdef STOP_BIT_HALT_EN
      state_d = stop_q ? StHalt : StFetch;
`else
      state_d = StFetch;
`endif
    end
  end

  assign bus.PCSrc     = pc_src;
  assign bus.JA        = ja_q;
  assign bus.BTA       = bta_q;
  assign bus.pc_en     = pc_en;
  assign bus.rs1       = rs1_q;
  assign bus.rs2       = rs2_q;
  assign bus.rd        = rd_q;
  assign bus.imm32     = imm_q;
  assign bus.shamt     = shamt_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_src   = alu_src_q;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.reg_write = reg_write;
  assign bus.wb_sel    = wb_sel_q;
  assign bus.illegal   = illegal;
  assign bus.busy      = (state_q != StFetch);

endmodule
